// File: rtl/nonce_batch_scheduler.sv
// Nonce batch scheduler: hands contiguous nonce batches to a pool of hash engines
// and reports completion once every batch of the run has been hashed.
`timescale 1ns/1ps
module nonce_batch_scheduler #(
   parameter int unsigned NUM_ENGINES  = 2,
   parameter int unsigned BATCH        = 8,
   parameter int unsigned TOTAL_NONCES = 16,
   parameter int unsigned NONCE_W      = 32
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic                           start,
   input  logic [NONCE_W-1:0]             base_nonce,
   input  logic [NUM_ENGINES-1:0]         eng_done,
   output logic [NUM_ENGINES-1:0]         eng_start,
   output logic [NUM_ENGINES*NONCE_W-1:0] eng_nonce,
   output logic                           busy,
   output logic                           done,
   output logic [7:0]                     jobs_left,
   output logic                           err
);

   localparam int unsigned JOBS = TOTAL_NONCES / BATCH;

   typedef enum logic [1:0] {
      IDLE,
      DISPATCH,
      DRAIN
   } state_e;

   state_e                         state_q, state_d;
   logic [NUM_ENGINES-1:0]         free_q, free_d;
   logic [NUM_ENGINES-1:0]         eng_start_q, eng_start_d;
   logic [NUM_ENGINES*NONCE_W-1:0] eng_nonce_q, eng_nonce_d;
   logic [NONCE_W-1:0]             next_nonce_q, next_nonce_d;
   logic [7:0]                     jobs_left_q, jobs_left_d;
   logic                           err_q, err_d;
   logic                           post_rst_q, post_rst_d;

   logic                           accept;
   logic                           can_dispatch;
   logic [NUM_ENGINES-1:0]         pick;
   logic [NUM_ENGINES-1:0]         done_ok;
   logic [NUM_ENGINES-1:0]         done_bad;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q      <= IDLE;
         free_q       <= '1;
         eng_start_q  <= '0;
         eng_nonce_q  <= '0;
         next_nonce_q <= '0;
         jobs_left_q  <= '0;
         err_q        <= 1'b0;
         post_rst_q   <= 1'b1;
      end else begin
         state_q      <= state_d;
         free_q       <= free_d;
         eng_start_q  <= eng_start_d;
         eng_nonce_q  <= eng_nonce_d;
         next_nonce_q <= next_nonce_d;
         jobs_left_q  <= jobs_left_d;
         err_q        <= err_d;
         post_rst_q   <= post_rst_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:     if (start) state_d = DISPATCH;
         DISPATCH: if (jobs_left_d == '0) state_d = DRAIN;
         DRAIN:    if (&free_d) state_d = IDLE;
         default:  state_d = IDLE;
      endcase
   end

   always_comb begin
      accept       = (state_q == IDLE) && start;
      can_dispatch = (state_q == DISPATCH) && (jobs_left_q != '0);

      // Eligibility uses last cycle's free mask, so an engine freed this cycle waits one cycle.
      pick = '0;
      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
         if (can_dispatch && free_q[i] && (pick == '0)) pick[i] = 1'b1;
      end

      done_ok  = eng_done & ~free_q;
      done_bad = eng_done & free_q;

      free_d       = (free_q | done_ok) & ~pick;
      eng_start_d  = pick;
      eng_nonce_d  = eng_nonce_q;
      next_nonce_d = next_nonce_q;
      jobs_left_d  = jobs_left_q;
      err_d        = err_q | ((|done_bad) & ~post_rst_q);
      post_rst_d   = post_rst_q;

      for (int unsigned i = 0; i < NUM_ENGINES; i++) begin
         if (pick[i]) eng_nonce_d[i*NONCE_W +: NONCE_W] = next_nonce_q;
      end

      if (|pick) begin
         next_nonce_d = next_nonce_q + NONCE_W'(BATCH);
         jobs_left_d  = jobs_left_q - 8'd1;
      end

      // Completions of jobs abandoned by reset stay silent until the next run starts.
      if (accept) begin
         next_nonce_d = base_nonce;
         jobs_left_d  = 8'(JOBS);
         free_d       = '1;
         err_d        = 1'b0;
         post_rst_d   = 1'b0;
      end
   end

   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == IDLE);
      eng_start = eng_start_q;
      eng_nonce = eng_nonce_q;
      jobs_left = jobs_left_q;
      err       = err_q;
   end

endmodule

// File: tb/tb_nonce_batch_scheduler.sv
// Scoreboard bench for nonce_batch_scheduler: a job-queue reference model predicts
// each engine start; a negedge monitor pops and compares every observed start.
`timescale 1ns/1ps
module tb_nonce_batch_scheduler;

   localparam int NE    = 2;
   localparam int BATCH = 8;
   localparam int TOTAL = 32;
   localparam int NW    = 32;
   localparam int JOBS  = TOTAL / BATCH;

   logic            clk = 1'b0;
   logic            reset_n;
   logic            start;
   logic [NW-1:0]   base_nonce;
   logic [NE-1:0]   eng_done;
   logic [NE-1:0]   eng_start;
   logic [NE*NW-1:0] eng_nonce;
   logic            busy, done, err;
   logic [7:0]      jobs_left;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   always #5 clk = ~clk;

   nonce_batch_scheduler #(
      .NUM_ENGINES (NE),
      .BATCH       (BATCH),
      .TOTAL_NONCES(TOTAL),
      .NONCE_W     (NW)
   ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .start     (start),
      .base_nonce(base_nonce),
      .eng_done  (eng_done),
      .eng_start (eng_start),
      .eng_nonce (eng_nonce),
      .busy      (busy),
      .done      (done),
      .jobs_left (jobs_left),
      .err       (err)
   );

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference model: a run is a queue of batch nonces; the lowest idle engine takes the head.
   typedef struct {
      int          cyc;
      int          eng;
      logic [31:0] nonce;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] m_jobs[$];
   int          m_phase = 0;       // 0 idle, 1 handing out jobs, 2 waiting for engines
   bit [NE-1:0] m_free  = '1;
   bit [NE-1:0] fb;
   bit          m_err   = 1'b0;
   bit          m_post  = 1'b1;
   exp_t        new_e;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_phase = 0;
         m_free  = '1;
         m_jobs.delete();
         m_err   = 1'b0;
         m_post  = 1'b1;
         exp_q.delete();
      end else begin
         cyc++;
         fb = m_free;
         if (m_phase == 0) begin
            if (start) begin
               m_jobs.delete();
               for (int j = 0; j < JOBS; j++) m_jobs.push_back(base_nonce + 32'(j * BATCH));
               m_free  = '1;
               m_err   = 1'b0;
               m_post  = 1'b0;
               m_phase = 1;
            end else if (eng_done != '0 && !m_post) begin
               m_err = 1'b1;
            end
         end else begin
            if (m_phase == 1 && m_jobs.size() > 0) begin
               for (int i = 0; i < NE; i++) begin
                  if (fb[i]) begin
                     new_e.cyc   = cyc;
                     new_e.eng   = i;
                     new_e.nonce = m_jobs.pop_front();
                     exp_q.push_back(new_e);
                     m_free[i] = 1'b0;
                     break;
                  end
               end
               if (m_jobs.size() == 0) m_phase = 2;
            end
            for (int i = 0; i < NE; i++) begin
               if (eng_done[i]) begin
                  if (!fb[i]) m_free[i] = 1'b1;
                  else if (!m_post) m_err = 1'b1;
               end
            end
            if (m_phase == 2 && m_free == '1) m_phase = 0;
         end
      end
   end

   exp_t mon_e;

   always @(negedge clk) begin
      if (reset_n === 1'b1) begin
         for (int i = 0; i < NE; i++) begin
            if (eng_start[i] === 1'b1) begin
               if (exp_q.size() == 0) begin
                  chk("start_unexpected", eng_start[i], 0);
               end else begin
                  mon_e = exp_q.pop_front();
                  chk("start_cycle", cyc, mon_e.cyc);
                  chk("start_engine", i, mon_e.eng);
                  chk("start_nonce", eng_nonce[i*NW +: NW], mon_e.nonce);
               end
            end
         end
         if (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
            mon_e = exp_q.pop_front();
            chk("start_missing", eng_start[mon_e.eng], 1);
         end
         chk("done", done, (m_phase == 0));
         chk("busy", busy, (m_phase != 0));
         chk("jobs_left", jobs_left, m_jobs.size());
         chk("err", err, m_err);
      end
   end

   // Engine emulation: each engine answers its start with a done pulse after a delay.
   int          cnt[NE];
   int          dly[NE];
   bit          rnd_dly   = 1'b0;
   bit          spur_en   = 1'b0;
   logic [NE-1:0] extra_done = '0;

   task automatic tick();
      logic [NE-1:0] dv;
      @(negedge clk);
      dv = '0;
      for (int i = 0; i < NE; i++) begin
         if (cnt[i] > 0) begin
            cnt[i]--;
            if (cnt[i] == 0) dv[i] = 1'b1;
         end
      end
      for (int i = 0; i < NE; i++) begin
         if (eng_start[i] === 1'b1) cnt[i] = rnd_dly ? int'($urandom_range(1, 12)) : dly[i];
      end
      if (spur_en && $urandom_range(0, 9) == 0) begin
         int j = int'($urandom_range(0, NE - 1));
         if (m_free[j] && cnt[j] == 0 && !dv[j]) dv[j] = 1'b1;
      end
      eng_done   = dv | extra_done;
      extra_done = '0;
   endtask

   task automatic run(input logic [31:0] base, input bit stray);
      bit finished = 1'b0;
      start      = 1'b1;
      base_nonce = base;
      tick();
      start = 1'b0;
      for (int n = 0; n < 1000; n++) begin
         if (stray && n == 1) begin
            start      = 1'b1;
            base_nonce = $urandom;
         end else begin
            start = 1'b0;
         end
         tick();
         if (done === 1'b1) begin
            finished = 1'b1;
            break;
         end
      end
      start = 1'b0;
      chk("run_completes", finished, 1);
      repeat (2) tick();
   endtask

   task automatic chk_reset_vals();
      chk("rst_eng_start", eng_start, 0);
      chk("rst_eng_nonce", eng_nonce, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 1);
      chk("rst_err", err, 0);
      chk("rst_jobs_left", jobs_left, 0);
   endtask

   initial begin
      reset_n    = 1'b1;
      start      = 1'b0;
      base_nonce = '0;
      eng_done   = '0;
      for (int i = 0; i < NE; i++) begin
         cnt[i] = 0;
         dly[i] = 1;
      end
      #1 reset_n = 1'b0;
      repeat (3) @(negedge clk);
      #1 chk_reset_vals();
      #1 reset_n = 1'b1;
      tick();

      // engine 1 finishes before engine 0
      dly[0] = 9; dly[1] = 3;
      run(32'h0000_0000, 1'b0);

      // lone spurious completion while idle raises the sticky flag
      extra_done = 2'b10;
      tick();
      tick();
      chk("err_spurious_idle", err, 1);

      // long engine 0, four jobs over two engines; start clears err
      dly[0] = 70; dly[1] = 40;
      run(32'h0000_1000, 1'b1);

      // both engines complete in the same cycle
      dly[0] = 5; dly[1] = 4;
      run(32'h0000_2000, 1'b0);

      // nonce wrap
      dly[0] = 3; dly[1] = 6;
      run(32'hFFFF_FFF8, 1'b0);

      // reset mid-dispatch, then stray completions after release
      dly[0] = 70; dly[1] = 70;
      start      = 1'b1;
      base_nonce = 32'd100;
      tick();
      start = 1'b0;
      repeat (4) tick();
      #2 reset_n = 1'b0;
      #1 chk_reset_vals();
      cnt[0] = 4;
      cnt[1] = 5;
      tick();
      #2 reset_n = 1'b1;
      repeat (5) tick();
      chk("err_after_reset", err, 0);
      dly[0] = 2; dly[1] = 7;
      run(32'h0000_3000, 1'b0);

      // randomized runs with spurious completions and stray starts
      rnd_dly = 1'b1;
      spur_en = 1'b1;
      for (int r = 0; r < 12; r++) begin
         run($urandom, 1'($urandom_range(0, 1)));
      end
      spur_en = 1'b0;
      repeat (5) tick();
      chk("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got running expected finished");
      $fatal(1, "watchdog");
   end

endmodule
